// File: rtl/sram_like_slave_pkg.sv
// sram_like_slave_pkg
//   Shared definitions for the SRAM-like responder: transfer size encodings,
//   response-entry layout and widths, the random-delay LFSR tap mask, and the
//   byte-lane merge helper used on write acceptance.
//   No ports (package).
package sram_like_slave_pkg;

  // Transfer size encoding carried on the size port.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int DATA_W  = 32;
  localparam int TIMER_W = 4;
  localparam int CNT_W   = 4;

  // Entry packing: wr flag in the top bit, read snapshot below it.
  localparam int ENTRY_DATA_LSB = 0;
  localparam int ENTRY_WR_BIT   = DATA_W;
  localparam int ENTRY_W        = DATA_W + 1;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } resp_entry_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Replace each byte lane of old_word whose strobe is set with the
  // matching lane of new_word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [3:0]        strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_like_slave_resp_fifo.sv
// sram_resp_fifo
//   In-order response buffer for the SRAM-like responder. Each entry carries
//   a write flag, a read-data snapshot and a countdown timer. An entry is
//   ready to answer once its timer has reached zero; only the head may answer.
//   Ports:
//     clk, resetn        clock, asynchronous active-low reset
//     push, push_entry   store a new entry at the tail
//     pop_en             allows a ready head to retire this cycle
//     head_ready         head is valid and its timer has expired
//     head_entry         contents of the head entry
//     count              number of buffered entries
module sram_resp_fifo
  import sram_like_slave_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  resp_entry_t      push_entry,
  input  logic             pop_en,
  output logic             head_ready,
  output resp_entry_t      head_entry,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  // The acceptance edge itself is the first of the RESP_LAT edges, so the
  // stored timer starts one lower; RESP_LAT=1 answers in the next cycle.
  localparam logic [TIMER_W-1:0] PUSH_TIME = TIMER_W'(RESP_LAT - 1);

  resp_entry_t        entries [DEPTH];
  logic [TIMER_W-1:0] timers  [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Empty is judged by count, so a wrapped pointer pair never looks ready.
  assign head_entry = entries[rd_ptr];
  assign head_ready = (count != '0) && (timers[rd_ptr] == '0);
  assign pop        = head_ready && pop_en;

  // Storage, timers, pointers and occupancy. Every timer counts down each
  // edge and sticks at zero; a stalled head simply stays ready. Push and pop
  // in the same edge move both pointers and leave count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
        timers[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          entries[i] <= push_entry;
          timers[i]  <= PUSH_TIME;
        end else if (timers[i] != '0) begin
          timers[i] <= timers[i] - 1'b1;
        end
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave
//   Responder side of the SRAM-like bus: word-addressed memory with a
//   bounded number of outstanding requests, fixed response latency and
//   in-order responses.
//   Optional feature macro: SRAM_SLAVE_RAND_DELAY_EN adds LFSR-driven
//   random masking of addr_ok and data_ok.
//   Ports:
//     clk, resetn        clock, asynchronous active-low reset
//     req, wr, size      request valid, write flag, transfer size (unused)
//     addr, wstrb, wdata byte address, lane enables, lane-replicated data
//     addr_ok            request accepted when req && addr_ok
//     data_ok, rdata     one-cycle response pulse and its read data
//     outstanding        number of accepted, unanswered requests
module sram_like_slave
  import sram_like_slave_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          RESP_LAT = 1,
  parameter int          MEM_AW   = 12,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [3:0]  outstanding
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] word_idx;
  logic              accept;
  logic              accept_gate;
  logic              resp_gate;
  logic              head_ready;
  resp_entry_t       push_entry;
  resp_entry_t       head_entry;
  logic [CNT_W-1:0]  count;
  logic              unused_bits;

  // Upper address bits alias onto the memory; size is carried but ignored.
  assign word_idx    = addr[MEM_AW+1:2];
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0], SEED};

`ifdef SRAM_SLAVE_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR that throttles both handshakes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= SEED;
    else         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign accept_gate = (lfsr[1:0] != 2'b00);
  assign resp_gate   = (lfsr[3:2] != 2'b00);
`else
  assign accept_gate = 1'b1;
  assign resp_gate   = 1'b1;
`endif

  // Depends only on state: a retirement in the same cycle never reopens
  // a full buffer early.
  assign addr_ok = resetn && (count < DEPTH_CNT) && accept_gate;
  assign accept  = req && addr_ok;

  // A read snapshots the word as it stands before this edge, which already
  // includes every write accepted on earlier edges.
  assign push_entry = '{wr: wr, data: (wr ? '0 : mem[word_idx])};

  // Memory contents survive reset; only accepted writes touch them.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[word_idx] <= merge_lanes(mem[word_idx], wdata, wstrb);
    end
  end

  sram_resp_fifo #(
    .DEPTH    (DEPTH),
    .RESP_LAT (RESP_LAT)
  ) u_resp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop_en     (resp_gate),
    .head_ready (head_ready),
    .head_entry (head_entry),
    .count      (count)
  );

  assign data_ok     = head_ready && resp_gate;
  assign rdata       = (data_ok && !head_entry.wr) ? head_entry.data : '0;
  assign outstanding = count;

endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave
//   Directed bench for sram_like_slave. Two instances share clock, reset and
//   request fields: u_fast (DEPTH=4, RESP_LAT=1) and u_slow (DEPTH=4,
//   RESP_LAT=8). With SRAM_SLAVE_RAND_DELAY_EN defined, a scoreboarded
//   random run on u_fast replaces the cycle-exact directed steps.
`timescale 1ns/1ps
module tb_sram_like_slave;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        req_f  = 1'b0;
  logic        req_s  = 1'b0;
  logic        wr     = 1'b0;
  logic [1:0]  size   = 2'd2;
  logic [31:0] addr   = '0;
  logic [3:0]  wstrb  = '0;
  logic [31:0] wdata  = '0;

  logic        aok_f, dok_f, aok_s, dok_s;
  logic [31:0] rdata_f, rdata_s;
  logic [3:0]  out_f, out_s;

  int total = 0;
  int bad   = 0;

  int          acc_k [5];
  int          dok_k [5];
  logic [31:0] dok_rd [5];
  logic        aok_k [41];
  int          out_k [41];
  int          n_acc, n_dok;
  logic [31:0] s_addr [5];
  logic [31:0] s_data [5];
  int          exp_acc [5] = '{1, 2, 3, 4, 10};
  int          exp_dok [5] = '{8, 9, 10, 11, 17};

  always #5 clk = ~clk;

  sram_like_slave #(.DEPTH(4), .RESP_LAT(1)) u_fast (
    .clk(clk), .resetn(resetn), .req(req_f), .wr(wr), .size(size),
    .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_f),
    .data_ok(dok_f), .rdata(rdata_f), .outstanding(out_f)
  );

  sram_like_slave #(.DEPTH(4), .RESP_LAT(8)) u_slow (
    .clk(clk), .resetn(resetn), .req(req_s), .wr(wr), .size(size),
    .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_s),
    .data_ok(dok_s), .rdata(rdata_s), .outstanding(out_s)
  );

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request to the fast instance.
  task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                                input logic [31:0] d);
    wr = w; addr = a; wstrb = s; wdata = d; req_f = 1'b1;
  endtask

  // Hold req on the slow instance for five requests, recording the edge of
  // every acceptance and response plus per-edge addr_ok/outstanding.
  task automatic slow_burst(input logic is_wr);
    int   acc, nd;
    logic will_acc;
    acc = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin acc_k[i] = -1; dok_k[i] = -1; dok_rd[i] = 'x; end
    wr = is_wr; wstrb = 4'hF; addr = s_addr[0]; wdata = s_data[0]; req_s = 1'b1;
    for (int k = 1; k <= 40 && nd < 5; k++) begin
      will_acc = req_s && aok_s;
      step();
      if (will_acc && acc < 5) begin
        acc_k[acc] = k;
        acc++;
        if (acc < 5) begin addr = s_addr[acc]; wdata = s_data[acc]; end
        else req_s = 1'b0;
      end
      aok_k[k] = aok_s;
      out_k[k] = out_s;
      if (dok_s) begin
        dok_k[nd]  = k;
        dok_rd[nd] = rdata_s;
        nd++;
      end
    end
    req_s = 1'b0;
    n_acc = acc; n_dok = nd;
  endtask

  task automatic slow_verify(input string pfx, input logic is_rd);
    check_output({pfx, "_nacc"}, 32'(n_acc), 32'd5);
    check_output({pfx, "_ndok"}, 32'(n_dok), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("%s_acc_edge%0d", pfx, i), 32'(acc_k[i]), 32'(exp_acc[i]));
      check_output($sformatf("%s_dok_edge%0d", pfx, i), 32'(dok_k[i]), 32'(exp_dok[i]));
      check_output($sformatf("%s_rdata%0d", pfx, i), dok_rd[i], is_rd ? s_data[i] : 32'd0);
    end
    check_output({pfx, "_full_out"}, 32'(out_k[4]), 32'd4);
    check_output({pfx, "_full_aok_k5"}, 32'(aok_k[5]), 32'd0);
    check_output({pfx, "_nobypass_aok_k8"}, 32'(aok_k[8]), 32'd0);
    check_output({pfx, "_reopen_aok_k9"}, 32'(aok_k[9]), 32'd1);
    check_output({pfx, "_reopen_out_k9"}, 32'(out_k[9]), 32'd3);
    check_output({pfx, "_pushpop_out_k10"}, 32'(out_k[10]), 32'd3);
    step();
    check_output({pfx, "_drain_dok"}, 32'(dok_s), 32'd0);
    check_output({pfx, "_drain_out"}, 32'(out_s), 32'd0);
  endtask

`ifdef SRAM_SLAVE_RAND_DELAY_EN
  // Random reads/writes on u_fast checked against a byte-merging shadow of
  // 16 words and a queue of expected responses.
  task automatic random_test();
    logic [31:0] model [16];
    logic [31:0] expq [$];
    logic [31:0] expv;
    logic        acc;
    int          ops, gaps, cyc, nacc, ndok, idx;
    ops = 0; gaps = 0; cyc = 0; nacc = 0; ndok = 0;
    wr = 1'b1; addr = 32'h400; wstrb = 4'hF; wdata = $urandom; req_f = 1'b1;
    while ((ops < 1016 || expq.size() != 0) && cyc < 30000) begin
      acc = req_f && aok_f;
      if (req_f && !aok_f && out_f < 4'd4) gaps++;
      step();
      cyc++;
      if (acc) begin
        idx = int'(addr[5:2]);
        if (wr) begin
          for (int b = 0; b < 4; b++) if (wstrb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
          expq.push_back(32'd0);
        end else begin
          expq.push_back(model[idx]);
        end
        ops++; nacc++;
        req_f = 1'b0;
      end
      if (dok_f) begin
        ndok++;
        if (expq.size() == 0) begin
          check_output("rand_extra_dok", 32'd1, 32'd0);
        end else begin
          expv = expq.pop_front();
          check_output($sformatf("rand_rdata_%0d", ndok), rdata_f, expv);
        end
      end
      if (!req_f && ops < 1016 && (ops < 16 || $urandom_range(0, 3) != 0)) begin
        if (ops < 16) begin
          wr = 1'b1; addr = 32'h400 + 32'(ops) * 4; wstrb = 4'hF; wdata = $urandom;
        end else begin
          wr = 1'($urandom_range(0, 1));
          addr = 32'h400 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
          wstrb = 4'($urandom_range(0, 15));
          wdata = $urandom;
        end
        req_f = 1'b1;
      end
    end
    check_output("rand_all_ops", 32'(ops), 32'd1016);
    check_output("rand_queue_empty", 32'(expq.size()), 32'd0);
    check_output("rand_dok_eq_acc", 32'(ndok), 32'(nacc));
    check_output("rand_addr_ok_gaps", 32'(gaps > 0), 32'd1);
  endtask
`endif

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int found;
    logic [31:0] found_rd;
    logic [31:0] pat;

    for (int i = 0; i < 5; i++) begin
      s_addr[i] = 32'h300 + 32'(i) * 4;
      s_data[i] = {16'h5A5A, 8'(i), 8'h3C};
    end

    // Reset values.
    step(); step();
    check_output("rst_aok", 32'(aok_f), 32'd0);
    check_output("rst_dok", 32'(dok_f), 32'd0);
    check_output("rst_rdata", rdata_f, 32'd0);
    check_output("rst_out", 32'(out_f), 32'd0);
    resetn = 1'b1;
    #1;

`ifdef SRAM_SLAVE_RAND_DELAY_EN
    random_test();
`else
    check_output("post_rst_aok", 32'(aok_f), 32'd1);

    // Preload word 0x10, then read it back one idle cycle later.
    apply_stimulus(1'b1, 32'h40, 4'hF, 32'h11223344);
    step();
    check_output("t1_wr_dok", 32'(dok_f), 32'd1);
    check_output("t1_wr_rdata", rdata_f, 32'd0);
    check_output("t1_wr_out", 32'(out_f), 32'd1);
    req_f = 1'b0;
    step();
    check_output("t1_idle_dok", 32'(dok_f), 32'd0);
    check_output("t1_idle_out", 32'(out_f), 32'd0);
    apply_stimulus(1'b0, 32'h40, 4'h0, 32'h0);
    check_output("t1_rd_aok", 32'(aok_f), 32'd1);
    step();
    check_output("t1_rd_dok", 32'(dok_f), 32'd1);
    check_output("t1_rd_rdata", rdata_f, 32'h11223344);
    check_output("t1_rd_out", 32'(out_f), 32'd1);
    req_f = 1'b0;
    step();
    check_output("t1_end_dok", 32'(dok_f), 32'd0);
    check_output("t1_end_rdata", rdata_f, 32'd0);
    check_output("t1_end_out", 32'(out_f), 32'd0);

    // Lane-1 write into a cleared word, read straight after.
    apply_stimulus(1'b1, 32'h140, 4'hF, 32'h0);
    step();
    req_f = 1'b0;
    step();
    apply_stimulus(1'b1, 32'h141, 4'b0010, 32'hAAAAAAAA);
    step();
    check_output("t2_wr_dok", 32'(dok_f), 32'd1);
    check_output("t2_wr_rdata", rdata_f, 32'd0);
    apply_stimulus(1'b0, 32'h140, 4'h0, 32'h0);
    step();
    check_output("t2_rd_dok", 32'(dok_f), 32'd1);
    check_output("t2_rd_rdata", rdata_f, 32'h0000AA00);
    check_output("t2_rd_out", 32'(out_f), 32'd1);
    req_f = 1'b0;
    step();

    // Eight back-to-back writes then eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      pat = {8'hA5, 8'h00, 8'(i), 8'(i)};
      apply_stimulus(1'b1, 32'h200 + 32'(i) * 4, 4'hF, pat);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      pat = {8'hA5, 8'h00, 8'(i), 8'(i)};
      apply_stimulus(1'b0, 32'h200 + 32'(i) * 4, 4'h0, 32'h0);
      step();
      check_output($sformatf("t4_dok%0d", i), 32'(dok_f), 32'd1);
      check_output($sformatf("t4_rdata%0d", i), rdata_f, pat);
      check_output($sformatf("t4_out%0d", i), 32'(out_f), 32'd1);
    end
    req_f = 1'b0;
    step();
    check_output("t4_end_dok", 32'(dok_f), 32'd0);
    check_output("t4_end_out", 32'(out_f), 32'd0);

    // Full buffer on the slow instance: writes first, then reads of them.
    slow_burst(1'b1);
    slow_verify("t3_wr", 1'b0);
    slow_burst(1'b0);
    slow_verify("t3_rd", 1'b1);

    // Reset with three reads pending.
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = s_addr[i]; req_s = 1'b1;
      step();
    end
    req_s = 1'b0;
    check_output("t5_pre_out", 32'(out_s), 32'd3);
    resetn = 1'b0;
    #1;
    check_output("t5_rst_dok", 32'(dok_s), 32'd0);
    check_output("t5_rst_out", 32'(out_s), 32'd0);
    check_output("t5_rst_aok", 32'(aok_s), 32'd0);
    check_output("t5_rst_rdata", rdata_s, 32'd0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dok_s) found++;
    end
    check_output("t5_rst_no_dok", 32'(found), 32'd0);
    resetn = 1'b1;
    #1;
    check_output("t5_rel_aok", 32'(aok_s), 32'd1);
    check_output("t5_rel_out", 32'(out_s), 32'd0);

    apply_stimulus(1'b0, 32'h140, 4'h0, 32'h0);
    step();
    req_f = 1'b0;
    check_output("t5_fast_keep_dok", 32'(dok_f), 32'd1);
    check_output("t5_fast_keep_rdata", rdata_f, 32'h0000AA00);

    addr = s_addr[1]; wr = 1'b0; req_s = 1'b1;
    step();
    req_s = 1'b0;
    found = -1; found_rd = 'x;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (dok_s) begin found = j; found_rd = rdata_s; break; end
    end
    check_output("t5_slow_lat", 32'(found), 32'd7);
    check_output("t5_slow_keep_rdata", found_rd, s_data[1]);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
